// File: rtl/imem_program_loader_if.sv
// Stream-in and instruction-memory write-side signals of the program loader.
// The slave modport is the loader's view; the master modport is the
// surrounding system (byte source plus instruction memory).
interface imem_program_loader_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BYTE_WIDTH = 8
);
  logic                  InValid;
  logic [BYTE_WIDTH-1:0] InData;
  logic                  InReady;
  logic                  IMWriteEn;
  logic [ADDR_WIDTH-1:0] IMAddr;
  logic [BUS_WIDTH-1:0]  IMWriteData;

  modport master (
    output InValid, InData,
    input  InReady, IMWriteEn, IMAddr, IMWriteData
  );

  modport slave (
    input  InValid, InData,
    output InReady, IMWriteEn, IMAddr, IMWriteData
  );
endinterface

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader.
// Takes a byte stream: a 16-bit word count (MSB first), then that many
// instructions of BUS_WIDTH bits each, MSB first. Each word is written to
// consecutive word addresses starting at 0. The CPU is held until the load
// finishes successfully.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | after reset, waiting for Start; CPU held
//  HDR    | accepting the two word-count bytes
//  LOAD   | accepting instruction bytes into the word register
//  WRITE  | one-cycle memory write strobe; stream stalled
//  DONE   | load finished, CPU released; stream ignored
//  ERROR  | word count larger than memory depth; CPU held
module imem_program_loader #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 Start,
  imem_program_loader_if.slave bus,
  output logic                 CPUHold,
  output logic                 Done,
  output logic                 Error
);

  localparam int          BYTES = BUS_WIDTH / BYTE_WIDTH;
  localparam int          BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [63:0] DEPTH = 64'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t                state;
  logic [BCW-1:0]        byteCnt;
  logic [ADDR_WIDTH-1:0] wordCnt;
  logic [15:0]           count;
  logic [BUS_WIDTH-1:0]  word;

  logic                  accept;
  logic [15:0]           hdrCount;
  logic [BUS_WIDTH-1:0]  nextWord;
  logic                  lastWord;

  // Transfer qualifier, header value as it completes, and the shifted word.
  // The last-word test is done on the pre-increment counter so a full-depth
  // load never needs the counter to reach 2^ADDR_WIDTH.
  assign accept   = bus.InValid & bus.InReady;
  assign hdrCount = {count[15:8], 8'(bus.InData)};
  assign nextWord = BUS_WIDTH'({word, bus.InData});
  assign lastWord = (32'(wordCnt) + 32'd1) == 32'(count);

  // Loader FSM; every output is a register updated here.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state           <= IDLE;
      byteCnt         <= '0;
      wordCnt         <= '0;
      count           <= '0;
      word            <= '0;
      bus.InReady     <= 1'b0;
      bus.IMWriteEn   <= 1'b0;
      bus.IMAddr      <= '0;
      bus.IMWriteData <= '0;
      CPUHold         <= 1'b1;
      Done            <= 1'b0;
      Error           <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (Start) begin
            state       <= HDR;
            bus.InReady <= 1'b1;
            CPUHold     <= 1'b1;
            Done        <= 1'b0;
            Error       <= 1'b0;
            byteCnt     <= '0;
            wordCnt     <= '0;
            count       <= '0;
          end
        end

        HDR: begin
          if (accept) begin
            if (byteCnt == '0) begin
              count[15:8] <= 8'(bus.InData);
              byteCnt     <= BCW'(1);
            end else begin
              count[7:0] <= 8'(bus.InData);
              byteCnt    <= '0;
              if (hdrCount == 16'd0) begin
                state       <= DONE;
                bus.InReady <= 1'b0;
                Done        <= 1'b1;
                CPUHold     <= 1'b0;
              end else if (64'(hdrCount) > DEPTH) begin
                state       <= ERROR;
                bus.InReady <= 1'b0;
                Error       <= 1'b1;
              end else begin
                state <= LOAD;
              end
            end
          end
        end

        LOAD: begin
          if (accept) begin
            word <= nextWord;
            if (byteCnt == BCW'(BYTES - 1)) begin
              byteCnt         <= '0;
              bus.IMWriteData <= nextWord;
              bus.IMAddr      <= wordCnt;
              bus.IMWriteEn   <= 1'b1;
              bus.InReady     <= 1'b0;
              state           <= WRITE;
            end else begin
              byteCnt <= byteCnt + 1'b1;
            end
          end
        end

        WRITE: begin
          bus.IMWriteEn <= 1'b0;
          wordCnt       <= wordCnt + 1'b1;
          if (lastWord) begin
            state   <= DONE;
            Done    <= 1'b1;
            CPUHold <= 1'b0;
          end else begin
            state       <= LOAD;
            bus.InReady <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          bus.InReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for the instruction-memory program loader (ADDR_WIDTH=4).
module tb_imem_program_loader;

  localparam int BW = 32;
  localparam int AW = 4;
  localparam int YW = 8;

  logic CLK = 1'b0;
  logic RST_n;
  logic Start;
  logic CPUHold, Done, Error;

  int vectors    = 0;
  int miscompares = 0;
  int cycle      = 0;
  int acceptCnt  = 0;

  logic [AW-1:0] wrAddr[$];
  logic [BW-1:0] wrData[$];
  int            wrCycle[$];
  logic [7:0]    stim[$];

  imem_program_loader_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .BYTE_WIDTH(YW)) bus ();

  imem_program_loader #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .BYTE_WIDTH(YW)) dut (
    .CLK    (CLK),
    .RST_n  (RST_n),
    .Start  (Start),
    .bus    (bus),
    .CPUHold(CPUHold),
    .Done   (Done),
    .Error  (Error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Log memory writes and stream transfers mid-cycle; the stream must be
  // stalled whenever the write strobe is up.
  always @(negedge CLK) begin
    if (RST_n === 1'b1) begin
      if (bus.IMWriteEn === 1'b1) begin
        wrAddr.push_back(bus.IMAddr);
        wrData.push_back(bus.IMWriteData);
        wrCycle.push_back(cycle);
        check("inReadyDuringWrite", 32'(bus.InReady), 32'd0);
      end
      if (bus.InValid === 1'b1 && bus.InReady === 1'b1) acceptCnt++;
    end
  end

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    wrCycle.delete();
  endtask

  task automatic pushHdr(input logic [15:0] n);
    stim.push_back(n[15:8]);
    stim.push_back(n[7:0]);
  endtask

  task automatic pushWord(input logic [31:0] w);
    stim.push_back(w[31:24]);
    stim.push_back(w[23:16]);
    stim.push_back(w[15:8]);
    stim.push_back(w[7:0]);
  endtask

  // Present one byte and return 1 ns after the edge that takes it.
  task automatic sendByte(input logic [7:0] b, input bit rnd);
    int guard = 0;
    bus.InData = b;
    if (rnd) begin
      while ($urandom_range(0, 1) == 1 && guard < 6) begin
        bus.InValid = 1'b0;
        @(posedge CLK);
        #1;
        guard++;
      end
    end
    bus.InValid = 1'b1;
    guard = 0;
    forever begin
      @(negedge CLK);
      if (bus.InReady === 1'b1) break;
      guard++;
      if (guard > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL sendTimeout: byte %0h never accepted", b);
        bus.InValid = 1'b0;
        return;
      end
    end
    @(posedge CLK);
    #1;
    bus.InValid = 1'b0;
  endtask

  task automatic sendStim(input bit rnd);
    foreach (stim[i]) sendByte(stim[i], rnd);
    stim.delete();
  endtask

  task automatic pulseStart();
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
  endtask

  task automatic checkTwoWords(input string tag, input logic [31:0] w0, input logic [31:0] w1);
    check({tag, "_count"}, 32'(wrAddr.size()), 32'd2);
    if (wrAddr.size() == 2) begin
      check({tag, "_addr0"}, 32'(wrAddr[0]), 32'd0);
      check({tag, "_data0"}, wrData[0], w0);
      check({tag, "_addr1"}, 32'(wrAddr[1]), 32'd1);
      check({tag, "_data1"}, wrData[1], w1);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_InReady"}, 32'(bus.InReady), 32'd0);
    check({tag, "_IMWriteEn"}, 32'(bus.IMWriteEn), 32'd0);
    check({tag, "_IMAddr"}, 32'(bus.IMAddr), 32'd0);
    check({tag, "_IMWriteData"}, bus.IMWriteData, 32'd0);
    check({tag, "_CPUHold"}, 32'(CPUHold), 32'd1);
    check({tag, "_Done"}, 32'(Done), 32'd0);
    check({tag, "_Error"}, 32'(Error), 32'd0);
  endtask

  initial begin
    int a0;
    logic [31:0] w;

    RST_n = 1'b0;
    Start = 1'b0;
    bus.InValid = 1'b0;
    bus.InData = '0;
    #12;
    checkResetOutputs("reset");
    @(negedge CLK);
    RST_n = 1'b1;
    @(posedge CLK);
    #1;

    // Basic two-word load, InValid held high.
    clearLog();
    pulseStart();
    check("startInReady", 32'(bus.InReady), 32'd1);
    pushHdr(16'd2);
    pushWord(32'h12345678);
    pushWord(32'h9ABCDEF0);
    sendStim(1'b0);
    check("lastWriteStrobe", 32'(bus.IMWriteEn), 32'd1);
    check("doneBeforeLastWrite", 32'(Done), 32'd0);
    @(posedge CLK);
    #1;
    check("basicDone", 32'(Done), 32'd1);
    check("basicCPUHold", 32'(CPUHold), 32'd0);
    check("basicInReady", 32'(bus.InReady), 32'd0);
    checkTwoWords("basic", 32'h12345678, 32'h9ABCDEF0);
    if (wrCycle.size() == 2) check("writeSpacing", 32'(wrCycle[1] - wrCycle[0]), 32'd5);

    // Zero-length program goes straight to DONE.
    clearLog();
    pulseStart();
    check("restartDone", 32'(Done), 32'd0);
    check("restartCPUHold", 32'(CPUHold), 32'd1);
    pushHdr(16'd0);
    sendStim(1'b0);
    check("zeroDone", 32'(Done), 32'd1);
    check("zeroCPUHold", 32'(CPUHold), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    check("zeroWrites", 32'(wrAddr.size()), 32'd0);

    // One word more than memory depth.
    clearLog();
    pulseStart();
    pushHdr(16'h0011);
    sendStim(1'b0);
    check("ovfError", 32'(Error), 32'd1);
    check("ovfCPUHold", 32'(CPUHold), 32'd1);
    check("ovfInReady", 32'(bus.InReady), 32'd0);
    check("ovfDone", 32'(Done), 32'd0);
    a0 = acceptCnt;
    bus.InData = 8'h5A;
    bus.InValid = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    bus.InValid = 1'b0;
    check("ovfNoAccept", 32'(acceptCnt - a0), 32'd0);
    check("ovfWrites", 32'(wrAddr.size()), 32'd0);

    // Exactly full depth: 16 words, last at address 15.
    clearLog();
    pulseStart();
    check("fullErrorCleared", 32'(Error), 32'd0);
    pushHdr(16'h0010);
    for (int i = 0; i < 16; i++) pushWord({8'(i), 8'hC3, 8'(15 - i), 8'h5A});
    sendStim(1'b0);
    check("fullLastAddr", 32'(bus.IMAddr), 32'd15);
    @(posedge CLK);
    #1;
    check("fullDone", 32'(Done), 32'd1);
    check("fullCount", 32'(wrAddr.size()), 32'd16);
    if (wrAddr.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        w = {8'(i), 8'hC3, 8'(15 - i), 8'h5A};
        check("fullAddr", 32'(wrAddr[i]), 32'(i));
        check("fullData", wrData[i], w);
      end
    end

    // Same two-word load with a bursty InValid.
    clearLog();
    pulseStart();
    a0 = acceptCnt;
    pushHdr(16'd2);
    pushWord(32'h12345678);
    pushWord(32'h9ABCDEF0);
    sendStim(1'b1);
    @(posedge CLK);
    #1;
    check("rndDone", 32'(Done), 32'd1);
    check("rndAccepted", 32'(acceptCnt - a0), 32'd10);
    checkTwoWords("rnd", 32'h12345678, 32'h9ABCDEF0);

    // Reset in the middle of a three-word load.
    clearLog();
    pulseStart();
    pushHdr(16'd3);
    pushWord(32'hCAFEF00D);
    sendStim(1'b0);
    check("midWriteStrobe", 32'(bus.IMWriteEn), 32'd1);
    RST_n = 1'b0;
    #1;
    checkResetOutputs("midReset");
    @(negedge CLK);
    RST_n = 1'b1;
    @(posedge CLK);
    #1;
    clearLog();
    pulseStart();
    pushHdr(16'd2);
    pushWord(32'h0BADBEEF);
    pushWord(32'h76543210);
    sendStim(1'b0);
    @(posedge CLK);
    #1;
    check("afterResetDone", 32'(Done), 32'd1);
    checkTwoWords("afterReset", 32'h0BADBEEF, 32'h76543210);

    // Bytes offered in DONE are refused; Start during LOAD is ignored.
    a0 = acceptCnt;
    bus.InData = 8'hAA;
    bus.InValid = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    bus.InValid = 1'b0;
    check("doneNoAccept", 32'(acceptCnt - a0), 32'd0);
    check("doneInReady", 32'(bus.InReady), 32'd0);
    check("doneStays", 32'(Done), 32'd1);
    clearLog();
    pulseStart();
    pushHdr(16'd2);
    stim.push_back(8'h11);
    stim.push_back(8'h22);
    sendStim(1'b0);
    pulseStart();
    stim.push_back(8'h33);
    stim.push_back(8'h44);
    pushWord(32'h55667788);
    sendStim(1'b0);
    @(posedge CLK);
    #1;
    check("ignStartDone", 32'(Done), 32'd1);
    check("ignStartError", 32'(Error), 32'd0);
    checkTwoWords("ignStart", 32'h11223344, 32'h55667788);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Write-side companion to the CPU's instruction-fetch path. The core only reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake: a 16-bit word-count header, then N 32-bit instructions, most-significant byte first.
- Writes each assembled word into instruction memory at consecutive word addresses starting at 0.
- Holds the CPU (gates its PC/pipeline) until the load completes.

Parameters:
- BUS_WIDTH, 32, instruction word width; must be a multiple of 8.
- ADDR_WIDTH, 10, instruction memory word-address width; depth is 2^ADDR_WIDTH words.
- BYTE_WIDTH, 8, width of the input stream symbol.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_n  input  1  asynchronous active-low reset.
- Start  input  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE or ERROR.
- InValid  input  1  stream byte valid.
- InData  input  BYTE_WIDTH  stream byte.
- InReady  output  1  loader can accept a byte; a transfer occurs when InValid and InReady are both 1 on a rising edge.
- IMWriteEn  output  1  instruction memory write strobe, one cycle per word.
- IMAddr  output  ADDR_WIDTH  instruction memory word address.
- IMWriteData  output  BUS_WIDTH  assembled instruction word.
- CPUHold  output  1  1 = CPU stalled (PC enable forced low).
- Done  output  1  load completed successfully.
- Error  output  1  header word count exceeds memory depth.

Behaviour:
- Reset (async, RST_n=0):
  - state=IDLE.
  - InReady=0, IMWriteEn=0, IMAddr=0, IMWriteData=0.
  - CPUHold=1, Done=0, Error=0.
  - Internal byte counter, word counter and count register cleared.
  - Reset asserted mid-load aborts immediately; memory contents already written are left as is.
- All outputs are registered.
- States: IDLE, HDR, LOAD, WRITE, DONE, ERROR.
- IDLE:
  - InReady=0, CPUHold=1.
  - Start=1 -> HDR; clear Done, Error and counters.
- HDR:
  - InReady=1.
  - First accepted byte -> count[15:8]; second accepted byte -> count[7:0].
  - After the second byte, the next state is chosen as follows:
    - count==0 -> DONE.
    - count > 2^ADDR_WIDTH -> ERROR.
    - otherwise -> LOAD.
- LOAD:
  - InReady=1.
  - Each accepted byte shifts into the word register: word = {word[BUS_WIDTH-9:0], InData}.
  - When the byte accepted is the (BUS_WIDTH/8)th byte of a word: next state WRITE.
  - On that same edge: IMWriteData <= completed word, IMAddr <= word counter, IMWriteEn <= 1, InReady <= 0.
- WRITE (exactly one cycle):
  - IMWriteEn=1 with stable IMAddr/IMWriteData; InReady=0, so no byte is accepted in this cycle.
  - Next edge: IMWriteEn <= 0 and the word counter increments.
  - If this was word count-1 -> DONE; otherwise -> LOAD with InReady <= 1.
- Throughput: 1 word per (BUS_WIDTH/8 + 1) cycles when InValid is held high. InValid low simply stalls; no timeout.
- DONE:
  - Done=1, CPUHold=0, InReady=0; bytes offered are ignored.
  - Start=1 -> HDR; reasserts CPUHold and clears Done.
- ERROR:
  - Error=1, CPUHold=1, InReady=0, no memory writes.
  - Start=1 -> HDR.
- Start is ignored in HDR, LOAD and WRITE.
- Address boundary: count == 2^ADDR_WIDTH is legal. The last word is written to address 2^ADDR_WIDTH-1, and the word counter is compared before it increments, so there is no wrap.
- Bytes arriving after the last word are not accepted, because InReady is 0 in DONE.

Test Plan:
- Reset, then Start; stream 00 02 | 12 34 56 78 | 9A BC DE F0 with InValid held high:
  - IMWriteEn pulses twice: addr 0 / 0x12345678, then addr 1 / 0x9ABCDEF0.
  - Pulses are 5 cycles apart.
  - Done=1 and CPUHold=0 one cycle after the second pulse.
- Header 00 00 -> DONE directly; no IMWriteEn pulse; Done=1, CPUHold falls.
- ADDR_WIDTH=4, header 00 11 (17 words) -> Error=1, CPUHold=1, InReady=0, no writes. Header 00 10 -> 16 writes, last at addr 15, Done=1.
- Same 2-word load with InValid toggling randomly (about 50%) -> identical writes and data; InReady=0 in every WRITE cycle; no byte lost or duplicated.
- Assert RST_n=0 after 6 bytes of a 3-word load -> all outputs return to reset values within the cycle (async). A subsequent Start plus a full stream loads correctly from addr 0.
- In DONE, keep offering bytes and pulse Start during LOAD of a second run -> no acceptance in DONE; the Start during LOAD is ignored. The second run completes with the correct word count.
